pdm_encoder: RTL

Stereo first-order sigma-delta modulator: accepts 16-bit left/right PCM samples over a valid/ready handshake and produces two 1-bit PDM streams. It is the transmit counterpart of the PDM decoder in the audio path and feeds `lft_PDM`/`rght_PDM` to the speaker driver or to the decoder in loopback. A new sample pair is applied once per frame of `FRAME_LEN` clocks. This matches the decoder's 1153-cycle accumulation window.

---
 rtl/pdm_encoder.sv | 71 +++++++
 1 files changed

// File: rtl/pdm_encoder.sv
// pdm_encoder: stereo first-order sigma-delta PDM modulator; PCM pair in via smpl_vld/smpl_rdy, PDM bits, frame_strt and sticky underrun out
module pdm_encoder #(
  parameter int DATA_W = 16,
  parameter int FRAME_LEN = 1153
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] lft_in,
  input  logic [DATA_W-1:0] rght_in,
  input  logic              smpl_vld,
  output logic              smpl_rdy,
  output logic              lft_PDM,
  output logic              rght_PDM,
  output logic              frame_strt,
  output logic              underrun,
  input  logic              underrun_clr
);
  localparam int CW = $clog2(FRAME_LEN);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] lp_q, lp_d, rp_q, rp_d, la_q, la_d, ra_q, ra_d, lacc_q, racc_q;
  logic pend_full_q, pend_full_d, lpdm_q, rpdm_q, fs_q, fs_d, ur_q, ur_d;
  logic bnd, xfer, load_act;
  logic [DATA_W:0] lsum, rsum;
  always_comb begin
    bnd = cnt_q == CW'(FRAME_LEN - 1);
    xfer = smpl_vld && !pend_full_q;
    load_act = bnd && (pend_full_q || xfer);
    cnt_d = bnd ? '0 : cnt_q + CW'(1);
    lp_d = (xfer && !bnd) ? lft_in : lp_q;
    rp_d = (xfer && !bnd) ? rght_in : rp_q;
    la_d = !load_act ? la_q : pend_full_q ? lp_q : lft_in;
    ra_d = !load_act ? ra_q : pend_full_q ? rp_q : rght_in;
    pend_full_d = bnd ? 1'b0 : (xfer || pend_full_q);
    fs_d = load_act;
    ur_d = (bnd && !load_act) || (ur_q && !underrun_clr);
    lsum = {1'b0, lacc_q} + {1'b0, la_q};
    rsum = {1'b0, racc_q} + {1'b0, ra_q};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      lp_q <= '0;
      rp_q <= '0;
      la_q <= '0;
      ra_q <= '0;
      lacc_q <= '0;
      racc_q <= '0;
      pend_full_q <= 1'b0;
      lpdm_q <= 1'b0;
      rpdm_q <= 1'b0;
      fs_q <= 1'b0;
      ur_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lp_q <= lp_d;
      rp_q <= rp_d;
      la_q <= la_d;
      ra_q <= ra_d;
      {lpdm_q, lacc_q} <= lsum;
      {rpdm_q, racc_q} <= rsum;
      pend_full_q <= pend_full_d;
      fs_q <= fs_d;
      ur_q <= ur_d;
    end
  end
  assign smpl_rdy = !pend_full_q;
  assign lft_PDM = lpdm_q;
  assign rght_PDM = rpdm_q;
  assign frame_strt = fs_q;
  assign underrun = ur_q;
endmodule
